// File: rtl/core_pkg.sv
// Shared core-wide widths for the pipeline stages.
// No logic; constants only.
// No flow control.
package core_pkg;
    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
endpackage

// File: rtl/data_memory.sv
// Word-organised data RAM with synchronous write and registered read-first output.
// Latency: 1 cycle from read enable to rdata.
// Backpressure: none; one access per edge, writes blocked while rst_n is low.
module data_memory
    import core_pkg::*;
#(
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);

    // Contents start at zero and deliberately survive reset.
    logic [XLEN-1:0] mem [MEM_DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem[addr] <= wdata;
        end
    end

    // Non-blocking read of the pre-edge array gives read-first on a same-index write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data memory access, branch decision and the MEM/WB pipeline register.
// Latency: 1 cycle for WB outputs; PCSrc/PCimm_out are combinational.
// Backpressure: none; no stall or flush, every edge captures.
module mem_stage
    import core_pkg::*;
#(
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Ctl_MemtoReg_in,
    input  logic                 Ctl_RegWrite_in,
    input  logic                 Ctl_MemRead_in,
    input  logic                 Ctl_MemWrite_in,
    input  logic                 Ctl_Branch_in,
    output logic                 Ctl_MemtoReg_out,
    output logic                 Ctl_RegWrite_out,
    input  logic [REG_IDX_W-1:0] Rd_in,
    output logic [REG_IDX_W-1:0] Rd_out,
    input  logic                 Zero_in,
    input  logic [XLEN-1:0]      Write_Data,
    input  logic [XLEN-1:0]      ALUresult_in,
    input  logic [XLEN-1:0]      PCimm_in,
    output logic                 PCSrc,
    output logic [XLEN-1:0]      Read_Data,
    output logic [XLEN-1:0]      ALUresult_out,
    output logic [XLEN-1:0]      PCimm_out
);

    // EX has already folded the compare into Zero_in, so every branch type reduces to this AND.
    assign PCSrc     = Ctl_Branch_in & Zero_in;
    assign PCimm_out = PCimm_in;

    // Upper address bits are dropped, so accesses wrap modulo MEM_DEPTH.
    data_memory #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_data_memory (
        .clk   (clk),
        .rst_n (reset),
        .we    (Ctl_MemWrite_in),
        .re    (Ctl_MemRead_in),
        .addr  (ALUresult_in[ADDR_W-1:0]),
        .wdata (Write_Data),
        .rdata (Read_Data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Ctl_MemtoReg_out <= 1'b0;
            Ctl_RegWrite_out <= 1'b0;
            Rd_out           <= '0;
            ALUresult_out    <= '0;
        end else begin
            Ctl_MemtoReg_out <= Ctl_MemtoReg_in;
            Ctl_RegWrite_out <= Ctl_RegWrite_in;
            Rd_out           <= Rd_in;
            ALUresult_out    <= ALUresult_in;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, stores/loads, pass-through, branch, wrap, read-first, mid-op reset.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_Branch_in;
    logic        Ctl_MemtoReg_out, Ctl_RegWrite_out;
    logic [4:0]  Rd_in, Rd_out;
    logic        Zero_in;
    logic [31:0] Write_Data, ALUresult_in, PCimm_in;
    logic        PCSrc;
    logic [31:0] Read_Data, ALUresult_out, PCimm_out;

    int checks = 0;
    int errors = 0;

    mem_stage #(.MEM_DEPTH(64), .ADDR_W(6)) dut (
        .clk              (clk),
        .reset            (reset),
        .Ctl_MemtoReg_in  (Ctl_MemtoReg_in),
        .Ctl_RegWrite_in  (Ctl_RegWrite_in),
        .Ctl_MemRead_in   (Ctl_MemRead_in),
        .Ctl_MemWrite_in  (Ctl_MemWrite_in),
        .Ctl_Branch_in    (Ctl_Branch_in),
        .Ctl_MemtoReg_out (Ctl_MemtoReg_out),
        .Ctl_RegWrite_out (Ctl_RegWrite_out),
        .Rd_in            (Rd_in),
        .Rd_out           (Rd_out),
        .Zero_in          (Zero_in),
        .Write_Data       (Write_Data),
        .ALUresult_in     (ALUresult_in),
        .PCimm_in         (PCimm_in),
        .PCSrc            (PCSrc),
        .Read_Data        (Read_Data),
        .ALUresult_out    (ALUresult_out),
        .PCimm_out        (PCimm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdat);
        Ctl_MemRead_in  = rd;
        Ctl_MemWrite_in = wr;
        ALUresult_in    = addr;
        Write_Data      = wdat;
    endtask

    initial begin
        // Reset asserted with a live store request that must be ignored.
        reset           = 1'b0;
        Ctl_MemtoReg_in = 1'b1;
        Ctl_RegWrite_in = 1'b1;
        Ctl_Branch_in   = 1'b1;
        Zero_in         = 1'b1;
        Rd_in           = 5'd13;
        PCimm_in        = 32'h0000_1234;
        set_mem(1'b1, 1'b1, 32'd20, 32'h0000_0099);
        #2;
        check("rst_rd_out",    32'(Rd_out), 32'd0);
        check("rst_regwrite",  32'(Ctl_RegWrite_out), 32'd0);
        check("rst_memtoreg",  32'(Ctl_MemtoReg_out), 32'd0);
        check("rst_read_data", Read_Data, 32'd0);
        check("rst_alu_out",   ALUresult_out, 32'd0);
        check("rst_pcsrc",     32'(PCSrc), 32'd1);
        check("rst_pcimm",     PCimm_out, 32'h0000_1234);
        tick();
        tick();
        check("rst_hold_rd",   32'(Rd_out), 32'd0);
        check("rst_hold_alu",  ALUresult_out, 32'd0);

        // Release mid-cycle; first capture happens at the following edge.
        #3;
        reset = 1'b1;
        Rd_in = 5'd3;
        Ctl_MemtoReg_in = 1'b0;
        set_mem(1'b0, 1'b0, 32'h55, 32'd0);
        #1;
        check("rel_before_edge", 32'(Rd_out), 32'd0);
        tick();
        check("rel_rd_out",  32'(Rd_out), 32'd3);
        check("rel_alu_out", ALUresult_out, 32'h55);

        // Three stores on consecutive edges.
        set_mem(1'b0, 1'b1, 32'd17, 32'd4); tick();
        set_mem(1'b0, 1'b1, 32'd12, 32'd5); tick();
        set_mem(1'b0, 1'b1, 32'd7,  32'd6); tick();

        set_mem(1'b1, 1'b0, 32'd17, 32'd0); tick(); check("load_17", Read_Data, 32'd4);
        set_mem(1'b1, 1'b0, 32'd12, 32'd0); tick(); check("load_12", Read_Data, 32'd5);
        set_mem(1'b1, 1'b0, 32'd7,  32'd0); tick(); check("load_7",  Read_Data, 32'd6);
        set_mem(1'b1, 1'b0, 32'd20, 32'd0); tick(); check("load_20", Read_Data, 32'd0);

        // Pass-through with MemRead low.
        Rd_in = 5'd9;
        Ctl_RegWrite_in = 1'b1;
        Ctl_MemtoReg_in = 1'b1;
        set_mem(1'b0, 1'b0, 32'hDEAD_BEEF, 32'd0);
        tick();
        check("pt_rd_out",    32'(Rd_out), 32'd9);
        check("pt_regwrite",  32'(Ctl_RegWrite_out), 32'd1);
        check("pt_memtoreg",  32'(Ctl_MemtoReg_out), 32'd1);
        check("pt_alu_out",   ALUresult_out, 32'hDEAD_BEEF);
        check("pt_read_zero", Read_Data, 32'd0);

        // Branch decision is purely combinational.
        Ctl_Branch_in = 1'b1; Zero_in = 1'b0; PCimm_in = 32'd32; #1;
        check("br_nt_pcsrc", 32'(PCSrc), 32'd0);
        check("br_nt_pcimm", PCimm_out, 32'd32);
        Ctl_Branch_in = 1'b1; Zero_in = 1'b1; PCimm_in = 32'd44; #1;
        check("br_t_pcsrc",  32'(PCSrc), 32'd1);
        check("br_t_pcimm",  PCimm_out, 32'd44);
        Ctl_Branch_in = 1'b0; Zero_in = 1'b1; #1;
        check("br_nobr_pcsrc", 32'(PCSrc), 32'd0);

        // Wrap-around: 67 aliases index 3.
        set_mem(1'b0, 1'b1, 32'd67, 32'hA5); tick();
        set_mem(1'b1, 1'b0, 32'd3,  32'd0);  tick(); check("wrap_load_3", Read_Data, 32'hA5);
        set_mem(1'b1, 1'b1, 32'd3,  32'h11); tick(); check("rf_old_word", Read_Data, 32'hA5);
        set_mem(1'b1, 1'b0, 32'd3,  32'd0);  tick(); check("rf_new_word", Read_Data, 32'h11);

        // Reset asserted between edges while a store to 5 is pending.
        set_mem(1'b0, 1'b1, 32'd5, 32'h77);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_read_data", Read_Data, 32'd0);
        check("mid_rst_alu_out",   ALUresult_out, 32'd0);
        check("mid_rst_rd_out",    32'(Rd_out), 32'd0);
        check("mid_rst_regwrite",  32'(Ctl_RegWrite_out), 32'd0);
        tick();
        check("mid_rst_hold_alu",  ALUresult_out, 32'd0);
        #3;
        reset = 1'b1;
        set_mem(1'b1, 1'b0, 32'd5,  32'd0); tick(); check("post_rst_load_5",  Read_Data, 32'd0);
        set_mem(1'b1, 1'b0, 32'd17, 32'd0); tick(); check("post_rst_load_17", Read_Data, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RISC-V core: word-organised data memory, branch decision and the MEM/WB pipeline register.
- Sits between the EX/MEM register (inputs) and the write-back stage (registered outputs).
- Branch target and PCSrc are combinational and go back to fetch.

Parameters:
- MEM_DEPTH, 64, number of 32-bit data words; must be a power of two.
- ADDR_W, 6, word-index width, equal to log2(MEM_DEPTH).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- Ctl_MemtoReg_in  in  1  WB mux select, from EX/MEM
- Ctl_RegWrite_in  in  1  register-file write enable, from EX/MEM
- Ctl_MemRead_in  in  1  load enable
- Ctl_MemWrite_in  in  1  store enable
- Ctl_Branch_in  in  1  instruction is a branch
- Ctl_MemtoReg_out  out  1  registered MemtoReg
- Ctl_RegWrite_out  out  1  registered RegWrite
- Rd_in  in  5  destination register index
- Rd_out  out  5  registered Rd
- Zero_in  in  1  ALU branch-condition flag
- Write_Data  in  32  store data (rs2 value)
- ALUresult_in  in  32  memory address / ALU result
- PCimm_in  in  32  branch target (PC+imm)
- PCSrc  out  1  take branch
- Read_Data  out  32  registered load data
- ALUresult_out  out  32  registered ALU result
- PCimm_out  out  32  branch target to fetch

Behaviour:
- Address: word index = ALUresult_in[ADDR_W-1:0]. No byte lanes and no alignment check. Upper bits are ignored, so addresses wrap modulo MEM_DEPTH.
- Store:
  - On rising clk, if reset=1 and Ctl_MemWrite_in=1, mem[index] <= Write_Data.
  - Full 32-bit word only.
  - No write occurs while reset=0.
- Load:
  - On rising clk, if Ctl_MemRead_in=1, Read_Data <= mem[index].
  - If Ctl_MemRead_in=0, Read_Data <= 0.
  - Latency is 1 cycle, aligned with the other MEM/WB outputs.
- Same-edge read and write to the same index: read-first. Read_Data gets the old word; the new word is visible on the next read.
- MemRead and MemWrite both 1: both actions are performed, using the read-first rule above.
- Pipeline register: on each rising clk, Ctl_MemtoReg_out, Ctl_RegWrite_out, Rd_out and ALUresult_out capture their inputs. There is no stall or flush input.
- Branch logic is combinational and unregistered:
  - PCSrc = Ctl_Branch_in & Zero_in.
  - PCimm_out = PCimm_in.
  - Zero_in already encodes the condition for beq/bne/blt/bge; EX resolves it.
- Reset (reset=0):
  - Immediately, without waiting for a clock, Ctl_MemtoReg_out=0, Ctl_RegWrite_out=0, Rd_out=0, Read_Data=0 and ALUresult_out=0.
  - Registers hold these values while reset stays low.
  - The first capture happens at the first rising edge after reset returns to 1.
- Reset does not clear memory contents:
  - Memory initialises to all zeros at time zero.
  - Contents are retained across reset.
  - A reset asserted mid-operation blocks any write on that edge.
- PCSrc and PCimm_out follow their inputs even during reset.

Decomposition:
- Shared package (core_pkg): XLEN=32, REG_IDX_W=5.
- One sub-module, data_memory: synchronous write, registered read-first output, parameterised by MEM_DEPTH and ADDR_W.
- mem_stage holds the pipeline register and branch logic.

Test Plan:
1. Reset behaviour: reset=0 with random inputs, checked mid-cycle -> all registered outputs are 0, PCSrc=Branch&Zero, PCimm_out=PCimm_in. Release reset -> outputs are updated at the next rising edge.
2. Stores then loads:
   - Store three words: {addr 17, data 4}, {addr 12, data 5}, {addr 7, data 6} on consecutive edges.
   - Then load addresses 17, 12, 7 -> Read_Data=4, 5, 6, each one cycle after its MemRead edge.
   - Load address 20 -> 0.
3. Pass-through:
   - Rd_in=9, RegWrite=1, MemtoReg=1, ALUresult_in=0xDEADBEEF -> outputs equal these values one edge later.
   - With MemRead=0 -> Read_Data=0.
4. Branch:
   - Branch=1, Zero=0, PCimm_in=32 -> PCSrc=0, PCimm_out=32.
   - Branch=1, Zero=1, PCimm_in=44 -> PCSrc=1, PCimm_out=44.
   - Branch=0, Zero=1 -> PCSrc=0.
5. Wrap-around and read-first:
   - Store 0xA5 at address 64+3 (MEM_DEPTH=64) -> load address 3 returns 0xA5.
   - On one edge, read address 3 and write 0x11 to it -> Read_Data=0xA5; the next read returns 0x11.
6. Reset mid-operation:
   - Assert reset between edges while MemWrite=1 to address 5, data 0x77 -> outputs clear asynchronously and no write occurs.
   - After release, load address 5 -> 0. Address 17 still reads 4 (memory retained across reset).
